// File: rtl/bit_interleaver_if.sv
// Serial bit interleaver port bundle.
// The upstream side (master) drives the scrambled bit stream and the flush
// pulse; the interleaver (slave) returns the permuted stream and status.
interface bit_interleaver_if;
  // Handshake: il_in is taken only on a rising edge where il_valid=1.
  // There is no ready; while il_busy=1 any valid bit is discarded and
  // flagged on il_drop. il_out is meaningful only where il_out_valid=1,
  // and the output side has no backpressure.
  logic il_in;
  logic il_valid;
  logic il_flush;
  logic il_out;
  logic il_out_valid;
  logic il_out_sob;
  logic il_busy;
  logic il_drop;

  modport master (
    output il_in, il_valid, il_flush,
    input  il_out, il_out_valid, il_out_sob, il_busy, il_drop
  );

  modport slave (
    input  il_in, il_valid, il_flush,
    output il_out, il_out_valid, il_out_sob, il_busy, il_drop
  );
endinterface

// File: rtl/bit_interleaver.sv
// Ping-pong block bit interleaver: rows are written in, columns are read out.
// Writer fills bank wb at linear address wc; a full bank is drained by the
// reader in column order, one bit per cycle. Flush zero-pads a partial block.
module bit_interleaver #(
  parameter int ROWS = 8,
  parameter int COLS = 12
) (
  input  logic           clk,
  input  logic           rst,
  bit_interleaver_if.slave bus,
  output logic           dbg_rd_state
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [RW-1:0] ROW_END = RW'(ROWS - 1);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_e;

  // Storage is intentionally not reset.
  logic [N-1:0] mem [2];

  // Write side
  logic          wb;
  logic [AW-1:0] wc;
  logic          busy;
  logic          drop;
  logic [1:0]    full;
  logic          accept;
  logic          wr_en;
  logic          wr_bit;
  logic          wr_last;
  logic          flush_go;

  // Read side
  rd_state_e     state, state_n;
  logic          rb, rb_n;
  logic [AW-1:0] rc, rc_n;
  logic [RW-1:0] rrow, rrow_n;
  logic [CW-1:0] rcol, rcol_n;
  logic          rd_load;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          sob_n;
  logic          clr_full;
  logic          avail_cur;
  logic          avail_oth;

  // Writer decode: padding writes zeros, otherwise accepted bits are stored.
  // A flush that coincides with the final bit of a block has nothing to pad.
  always_comb begin
    accept   = bus.il_valid & ~busy;
    wr_en    = accept | busy;
    wr_bit   = busy ? 1'b0 : bus.il_in;
    wr_last  = wr_en & (wc == LAST);
    flush_go = bus.il_flush & ~busy & ((wc != '0) | accept) & ~wr_last;
  end

  // Writer counters, pad state and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb   <= 1'b0;
      wc   <= '0;
      busy <= 1'b0;
      drop <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_last) begin
          wc   <= '0;
          wb   <= ~wb;
          busy <= 1'b0;
        end else begin
          wc <= wc + 1'b1;
        end
      end
      if (flush_go) begin
        busy <= 1'b1;
      end
      if (bus.il_valid & busy) begin
        drop <= 1'b1;
      end
    end
  end

  // Bit storage for both banks.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wb][wc] <= wr_bit;
    end
  end

  // Bank full flags: set by the writer on completion, cleared by the reader.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (wr_last) begin
        full[wb] <= 1'b1;
      end
      if (clr_full) begin
        full[rb] <= 1'b0;
      end
    end
  end

  // A bank counts as available if already full or completing on this edge,
  // so its first bit (written long before) can be launched immediately.
  always_comb begin
    avail_cur = full[rb]  | (wr_last & (wb == rb));
    avail_oth = full[~rb] | (wr_last & (wb != rb));
  end

  // Reader next-state: rc tracks the bit currently shown on il_out.
  always_comb begin
    state_n  = state;
    rb_n     = rb;
    rc_n     = rc;
    rrow_n   = rrow;
    rcol_n   = rcol;
    rd_load  = 1'b0;
    rd_bank  = rb;
    rd_addr  = '0;
    sob_n    = 1'b0;
    clr_full = 1'b0;
    case (state)
      RD_IDLE: begin
        if (avail_cur) begin
          state_n = RD_RUN;
          rc_n    = '0;
          rrow_n  = '0;
          rcol_n  = '0;
          rd_load = 1'b1;
          sob_n   = 1'b1;
        end
      end
      RD_RUN: begin
        if (rc == LAST) begin
          clr_full = 1'b1;
          rb_n     = ~rb;
          rc_n     = '0;
          rrow_n   = '0;
          rcol_n   = '0;
          if (avail_oth) begin
            rd_load = 1'b1;
            rd_bank = ~rb;
            sob_n   = 1'b1;
          end else begin
            state_n = RD_IDLE;
          end
        end else begin
          rc_n = rc + 1'b1;
          if (rrow == ROW_END) begin
            rrow_n = '0;
            rcol_n = rcol + 1'b1;
          end else begin
            rrow_n = rrow + 1'b1;
          end
          rd_load = 1'b1;
          rd_addr = AW'(int'(rrow_n) * COLS + int'(rcol_n));
        end
      end
      default: state_n = RD_IDLE;
    endcase
  end

  // Reader state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RD_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Reader counters and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb               <= 1'b0;
      rc               <= '0;
      rrow             <= '0;
      rcol             <= '0;
      bus.il_out       <= 1'b0;
      bus.il_out_valid <= 1'b0;
      bus.il_out_sob   <= 1'b0;
    end else begin
      rb               <= rb_n;
      rc               <= rc_n;
      rrow             <= rrow_n;
      rcol             <= rcol_n;
      bus.il_out       <= rd_load ? mem[rd_bank][rd_addr] : 1'b0;
      bus.il_out_valid <= rd_load;
      bus.il_out_sob   <= sob_n;
    end
  end

  assign bus.il_busy   = busy;
  assign bus.il_drop   = drop;
  assign dbg_rd_state  = state;

  // The reader always frees a bank before the writer can need it again.
  assert property (@(posedge clk) disable iff (rst) !(wr_en && full[wb]));

endmodule

// File: tb/tb_bit_interleaver.sv
// Directed bench for bit_interleaver: a small 4x3 instance for permutation
// and flush behaviour, and a default 8x12 instance for streaming and reset.
module tb_bit_interleaver;
  localparam int SR = 4;
  localparam int SC = 3;
  localparam int SN = SR * SC;
  localparam int DR = 8;
  localparam int DC = 12;
  localparam int DN = DR * DC;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_interleaver_if s_if ();
  bit_interleaver_if d_if ();
  logic s_dbg;
  logic d_dbg;

  bit_interleaver #(.ROWS(SR), .COLS(SC)) u_small (
    .clk(clk), .rst(rst), .bus(s_if), .dbg_rd_state(s_dbg)
  );
  bit_interleaver #(.ROWS(DR), .COLS(DC)) u_dflt (
    .clk(clk), .rst(rst), .bus(d_if), .dbg_rd_state(d_dbg)
  );

  // Scoreboard state
  int   checks = 0;
  int   failures = 0;
  logic [0:0] exp_q[$];
  logic s_bits[$];
  logic s_sobs[$];
  int   s_cycs[$];
  logic d_bits[$];
  logic d_sobs[$];
  int   d_cycs[$];
  logic d_in[$];
  logic [6:0] prbs;

  int perm [SN] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
  int fl5  [SN] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
  int fl3  [SN] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

  int   blk_edge [SN];
  int   g_edge [2];
  int   first_edge;
  int   accepted;
  int   gblk;
  int   t;
  int   n;
  int   idx;
  logic b;
  logic v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and capture any valid output from both instances.
  task automatic tick();
    @(posedge clk);
    #1;
    if (s_if.il_out_valid === 1'b1) begin
      s_bits.push_back(s_if.il_out);
      s_sobs.push_back(s_if.il_out_sob);
      s_cycs.push_back(cyc);
    end
    if (d_if.il_out_valid === 1'b1) begin
      d_bits.push_back(d_if.il_out);
      d_sobs.push_back(d_if.il_out_sob);
      d_cycs.push_back(cyc);
    end
  endtask

  task automatic s_drive(input logic vv, input logic bb, input logic ff);
    s_if.il_valid = vv;
    s_if.il_in    = bb;
    s_if.il_flush = ff;
  endtask

  task automatic d_drive(input logic vv, input logic bb, input logic ff);
    d_if.il_valid = vv;
    d_if.il_in    = bb;
    d_if.il_flush = ff;
  endtask

  task automatic prbs_bit(output logic ob);
    ob   = prbs[6] ^ prbs[5];
    prbs = {prbs[5:0], ob};
  endtask

  task automatic clear_caps();
    s_bits.delete(); s_sobs.delete(); s_cycs.delete();
    d_bits.delete(); d_sobs.delete(); d_cycs.delete();
  endtask

  // Column-wise read of a row-wise written block: out k <- in[(k%R)*C + k/R].
  task automatic d_build_exp(input int base);
    for (int k = 0; k < DN; k++) begin
      exp_q.push_back(d_in[base + (k % DR) * DC + k / DR]);
    end
  endtask

  task automatic check_d_stream(input string tag, input int nbits, input int start_cyc);
    chk({tag, "_count"}, d_bits.size(), nbits);
    if (d_bits.size() == nbits) begin
      for (int k = 0; k < nbits; k++) begin
        chk({tag, "_bit"}, d_bits[k], exp_q[k]);
        chk({tag, "_sob"}, d_sobs[k], (k % DN) == 0);
      end
      chk({tag, "_start"}, d_cycs[0], start_cyc);
    end
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    repeat (3) begin
      s_drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      d_drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    chk("rst_s_out", s_if.il_out, 0);
    chk("rst_s_valid", s_if.il_out_valid, 0);
    chk("rst_s_sob", s_if.il_out_sob, 0);
    chk("rst_s_busy", s_if.il_busy, 0);
    chk("rst_s_drop", s_if.il_drop, 0);
    chk("rst_d_out", d_if.il_out, 0);
    chk("rst_d_valid", d_if.il_out_valid, 0);
    chk("rst_d_sob", d_if.il_out_sob, 0);
    chk("rst_d_busy", d_if.il_busy, 0);
    chk("rst_d_drop", d_if.il_drop, 0);
    chk("rst_d_state", d_dbg, 0);
    rst = 1'b0;
    s_drive(0, 0, 0);
    d_drive(0, 0, 0);
    clear_caps();

    // Permutation: twelve back-to-back blocks, block m carries a marker at m
    for (int m = 0; m < SN; m++) begin
      for (int i = 0; i < SN; i++) begin
        s_drive(1, 1'(i == m), 0);
        tick();
        if (m == 0 && i < SN - 1) chk("perm_novalid", s_if.il_out_valid, 0);
        if (i == SN - 1) blk_edge[m] = cyc;
      end
      if (m == 0) begin
        chk("perm_first_valid", s_if.il_out_valid, 1);
        chk("perm_first_sob", s_if.il_out_sob, 1);
      end
    end
    s_drive(0, 0, 0);
    repeat (SN + 2) tick();
    chk("perm_count", s_bits.size(), SN * SN);
    if (s_bits.size() == SN * SN) begin
      for (int m = 0; m < SN; m++) begin
        chk("perm_start", s_cycs[m * SN], blk_edge[m]);
        for (int p = 0; p < SN; p++) begin
          idx = m * SN + p;
          chk("perm_bit", s_bits[idx], perm[p] == m);
          chk("perm_sob", s_sobs[idx], p == 0);
        end
      end
    end
    chk("perm_idle_state", s_dbg, 0);
    clear_caps();

    // Continuous streaming: five PRBS-7 blocks
    prbs = 7'h7F;
    d_in.delete();
    for (int i = 0; i < 5 * DN; i++) begin
      prbs_bit(b);
      d_in.push_back(b);
      d_drive(1, b, 0);
      tick();
      if (i == DN - 1) first_edge = cyc;
    end
    d_drive(0, 0, 0);
    repeat (DN + 4) tick();
    exp_q.delete();
    for (int k = 0; k < 5; k++) d_build_exp(k * DN);
    check_d_stream("stream", 5 * DN, first_edge);
    if (d_cycs.size() == 5 * DN) begin
      for (int k = 1; k < 5 * DN; k++) chk("stream_gapfree", d_cycs[k], d_cycs[0] + k);
    end
    clear_caps();

    // Gapped input at roughly 50% duty, two blocks
    d_in.delete();
    accepted = 0;
    gblk = 0;
    while (accepted < 2 * DN) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        prbs_bit(b);
        d_drive(1, b, 0);
      end else begin
        d_drive(0, 1'($urandom_range(0, 1)), 0);
      end
      tick();
      if (v) begin
        d_in.push_back(b);
        accepted++;
        if (accepted % DN == 0) begin
          g_edge[gblk] = cyc;
          gblk++;
        end
      end
    end
    d_drive(0, 0, 0);
    repeat (DN + 4) tick();
    exp_q.delete();
    d_build_exp(0);
    d_build_exp(DN);
    check_d_stream("gapped", 2 * DN, g_edge[0]);
    if (d_cycs.size() == 2 * DN) begin
      chk("gapped_start1", d_cycs[DN], g_edge[1]);
      for (int k = 1; k < DN; k++) begin
        chk("gapped_run0", d_cycs[k], d_cycs[0] + k);
        chk("gapped_run1", d_cycs[DN + k], d_cycs[DN] + k);
      end
    end
    clear_caps();

    // Flush with nothing written: no effect
    s_drive(0, 0, 1);
    tick();
    s_drive(0, 0, 0);
    chk("flush_empty_busy", s_if.il_busy, 0);
    tick();
    chk("flush_empty_busy2", s_if.il_busy, 0);

    // Five ones, then a flush: 7 pad cycles, one dropped bit during padding
    for (int i = 0; i < 5; i++) begin
      s_drive(1, 1, 0);
      tick();
    end
    s_drive(0, 0, 1);
    tick();
    s_drive(0, 0, 0);
    chk("flush5_busy", s_if.il_busy, 1);
    for (int k = 2; k <= 7; k++) begin
      if (k == 3) s_drive(1, 1, 0);
      tick();
      s_drive(0, 0, 0);
      chk("flush5_busy", s_if.il_busy, 1);
      chk("flush5_novalid", s_if.il_out_valid, 0);
      if (k == 2) chk("flush5_drop_clear", s_if.il_drop, 0);
      if (k == 3) chk("flush5_drop_set", s_if.il_drop, 1);
    end
    tick();
    chk("flush5_busy_fall", s_if.il_busy, 0);
    chk("flush5_valid", s_if.il_out_valid, 1);
    chk("flush5_sob", s_if.il_out_sob, 1);
    repeat (SN + 2) tick();
    chk("flush5_count", s_bits.size(), SN);
    if (s_bits.size() == SN) begin
      for (int p = 0; p < SN; p++) begin
        chk("flush5_bit", s_bits[p], fl5[p]);
        chk("flush5_bsob", s_sobs[p], p == 0);
      end
    end
    chk("flush5_drop_sticky", s_if.il_drop, 1);
    clear_caps();

    // Flush together with the third bit; a second flush while padding is ignored
    for (int i = 0; i < 3; i++) begin
      s_drive(1, 1, 1'(i == 2));
      tick();
    end
    s_drive(0, 0, 0);
    chk("flush3_busy", s_if.il_busy, 1);
    for (int k = 2; k <= 9; k++) begin
      s_drive(0, 0, 1'(k == 2));
      tick();
      s_drive(0, 0, 0);
      chk("flush3_busy", s_if.il_busy, 1);
    end
    tick();
    chk("flush3_busy_fall", s_if.il_busy, 0);
    chk("flush3_valid", s_if.il_out_valid, 1);
    repeat (SN + 4) tick();
    chk("flush3_count", s_bits.size(), SN);
    if (s_bits.size() == SN) begin
      for (int p = 0; p < SN; p++) chk("flush3_bit", s_bits[p], fl3[p]);
    end
    chk("flush3_idle_busy", s_if.il_busy, 0);
    clear_caps();

    // Mid-operation reset at output bit 40 of the second block
    d_in.delete();
    t = 0;
    while (d_bits.size() < DN + 41 && t < 2000) begin
      prbs_bit(b);
      d_drive(1, b, 0);
      tick();
      t++;
    end
    chk("midrst_reach", d_bits.size(), DN + 41);
    if (d_bits.size() == DN + 41) chk("midrst_blk1_sob", d_sobs[DN], 1);
    rst = 1'b1;
    d_drive(0, 0, 0);
    tick();
    chk("midrst_valid", d_if.il_out_valid, 0);
    chk("midrst_sob", d_if.il_out_sob, 0);
    chk("midrst_out", d_if.il_out, 0);
    chk("midrst_busy", d_if.il_busy, 0);
    chk("midrst_state", d_dbg, 0);
    chk("midrst_s_drop", s_if.il_drop, 0);
    rst = 1'b0;
    n = d_bits.size();
    repeat (2 * DN) tick();
    chk("midrst_quiet", d_bits.size(), n);
    clear_caps();
    d_in.delete();
    for (int i = 0; i < DN; i++) begin
      prbs_bit(b);
      d_in.push_back(b);
      d_drive(1, b, 0);
      tick();
      if (i == DN - 1) first_edge = cyc;
    end
    d_drive(0, 0, 0);
    repeat (DN + 4) tick();
    exp_q.delete();
    d_build_exp(0);
    check_d_stream("after_rst", DN, first_edge);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
